regfile_wb_port: RTL



---
 rtl/regfile_wb_port_pkg.sv | 17 +
 rtl/regfile_wb_port_md_scoreboard.sv | 77 +++++++
 rtl/regfile_wb_port.sv | 80 ++++++++
 3 files changed

// File: rtl/regfile_wb_port_pkg.sv
// Shared constants and scoreboard state type for the architectural register file.
package regfile_wb_port_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_W      = $clog2(NUM_REGS);

  localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [REG_W-1:0] REG_STATUS = 5'd30;
  localparam logic [REG_W-1:0] REG_RA     = 5'd31;

  typedef enum logic {
    SB_IDLE,
    SB_PENDING
  } sb_state_e;

endpackage

// File: rtl/regfile_wb_port_md_scoreboard.sv
// One-entry scoreboard tracking the destination of the in-flight mult/div op
// so decode can stall on it; flags a sticky error on issue while busy.
module regfile_wb_port_md_scoreboard
  import regfile_wb_port_pkg::*;
#(
  parameter int unsigned IDX_W = REG_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_issue,
  input  logic [IDX_W-1:0] i_issue_reg,
  input  logic             i_retire,
  input  logic [IDX_W-1:0] i_read_a,
  input  logic [IDX_W-1:0] i_read_b,
  output logic             o_busy_a,
  output logic             o_busy_b,
  output logic             o_md_busy,
  output logic             o_overlap
);

  sb_state_e        r_state, w_state_next;
  logic [IDX_W-1:0] r_pend_reg, w_pend_next;
  logic             r_overlap, w_overlap_next;
  logic             w_issue_ok;
  logic             w_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SB_IDLE;
      r_pend_reg <= '0;
      r_overlap  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pend_reg <= w_pend_next;
      r_overlap  <= w_overlap_next;
    end
  end

  assign w_issue_ok = i_issue && (i_issue_reg != '0);

  always_comb begin
    w_state_next   = r_state;
    w_pend_next    = r_pend_reg;
    w_overlap_next = r_overlap;
    case (r_state)
      SB_IDLE: begin
        if (w_issue_ok) begin
          w_state_next = SB_PENDING;
          w_pend_next  = i_issue_reg;
        end
      end
      SB_PENDING: begin
        // Retire frees the entry first, so a same-cycle issue is legal.
        if (i_retire) begin
          if (w_issue_ok) begin
            w_pend_next = i_issue_reg;
          end else begin
            w_state_next = SB_IDLE;
          end
        end else if (i_issue) begin
          w_overlap_next = 1'b1;
        end
      end
      default: w_state_next = SB_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == SB_PENDING);
    o_md_busy = w_busy;
    o_overlap = r_overlap;
    // The retiring write is bypassed to the read ports, so no stall that cycle.
    o_busy_a  = w_busy && (r_pend_reg == i_read_a) && (i_read_a != '0) && !i_retire;
    o_busy_b  = w_busy && (r_pend_reg == i_read_b) && (i_read_b != '0) && !i_retire;
  end

endmodule

// File: rtl/regfile_wb_port.sv
// Architectural register file with writeback port, two bypassed read ports
// and a mult/div destination scoreboard. Register 0 reads as zero.
module regfile_wb_port #(
  parameter int unsigned DATA_WIDTH = regfile_wb_port_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = regfile_wb_port_pkg::NUM_REGS
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ctrl_writeEnable,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]       data_writeReg,
  input  logic                        wb_is_multdiv,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_readRegA,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]       data_readRegA,
  output logic [DATA_WIDTH-1:0]       data_readRegB,
  input  logic                        md_issue,
  input  logic [$clog2(NUM_REGS)-1:0] md_issue_reg,
  output logic                        busy_A,
  output logic                        busy_B,
  output logic                        md_busy,
  output logic                        md_overlap
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
  logic                  w_retire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (ctrl_writeEnable && (ctrl_writeReg != '0)) begin
      r_regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  always_comb begin
    data_readRegA = '0;
    if (ctrl_readRegA != '0) begin
      if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) begin
        data_readRegA = data_writeReg;
      end else begin
        data_readRegA = r_regs[ctrl_readRegA];
      end
    end
  end

  always_comb begin
    data_readRegB = '0;
    if (ctrl_readRegB != '0) begin
      if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) begin
        data_readRegB = data_writeReg;
      end else begin
        data_readRegB = r_regs[ctrl_readRegB];
      end
    end
  end

  assign w_retire = ctrl_writeEnable && wb_is_multdiv;

  regfile_wb_port_md_scoreboard #(
    .IDX_W (IdxW)
  ) u_md_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_issue     (md_issue),
    .i_issue_reg (md_issue_reg),
    .i_retire    (w_retire),
    .i_read_a    (ctrl_readRegA),
    .i_read_b    (ctrl_readRegB),
    .o_busy_a    (busy_A),
    .o_busy_b    (busy_B),
    .o_md_busy   (md_busy),
    .o_overlap   (md_overlap)
  );

endmodule
